// File: rtl/foodfight_bus_pkg.sv
// Shared bus definitions for the code-ROM read path: FSM states, ROM geometry
// and the default location of the 64 KB code window.
package foodfight_bus_pkg;

  localparam int CODE_BANKS  = 4;
  localparam int CODE_ROM_AW = 13;
  localparam logic [7:0] CODE_BASE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_ACK   = 3'd4
  } code_state_t;

endpackage

// File: rtl/code_bus_ctl_if.sv
// 68000-side bus bundle seen by the code ROM controller.
// Handshake: a cycle starts when cpu_as_n is low with a region hit; it completes
// when cpu_dtack_n goes low, and ends only once the CPU raises cpu_as_n again.
interface code_bus_ctl_if;
  logic [23:1] cpu_a;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic [15:0] cpu_d_out;
  logic        cpu_dtack_n;
  logic        sel;
  logic        wr_ignored;

  modport master (
    output cpu_a, cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n,
    input  cpu_d_out, cpu_dtack_n, sel, wr_ignored
  );

  modport slave (
    input  cpu_a, cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n,
    output cpu_d_out, cpu_dtack_n, sel, wr_ignored
  );
endinterface

// File: rtl/code_bus_ctl.sv
// Read controller for the program ROM window: decodes the CPU cycle, drives the
// banked ROM address/chip-enables, waits out ROM latency and returns DTACK.
module code_bus_ctl
  import foodfight_bus_pkg::*;
#(
  parameter logic [7:0]  BASE        = CODE_BASE,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  code_bus_ctl_if.slave          bus,
  output logic [CODE_ROM_AW-1:0] rom_a,
  output logic [CODE_BANKS-1:0]  rom_ce_n,
  input  logic [7:0]             rom_hi_d,
  input  logic [7:0]             rom_lo_d,
  output code_state_t            state_dbg
);

  if (WAIT_STATES > 7) begin : g_bad_wait_states
    $error("code_bus_ctl: WAIT_STATES must be 0..7");
  end

  localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  code_state_t            state, state_n;
  logic [2:0]             cnt, cnt_n;
  logic [CODE_ROM_AW-1:0] rom_a_q, rom_a_n;
  logic [CODE_BANKS-1:0]  ce_q, ce_n;
  logic [15:0]            dout_q, dout_n;
  logic                   dtack_q, dtack_n;
  logic                   wr_q, wr_n;
  logic                   hit;

  assign hit = ~bus.cpu_as_n & (bus.cpu_a[23:16] == BASE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      rom_a_q <= '0;
      ce_q    <= '1;
      dout_q  <= 16'h0000;
      dtack_q <= 1'b1;
      wr_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rom_a_q <= rom_a_n;
      ce_q    <= ce_n;
      dout_q  <= dout_n;
      dtack_q <= dtack_n;
      wr_q    <= wr_n;
    end
  end

  // Address and bank are captured only in IDLE; later changes are ignored.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rom_a_n = rom_a_q;
    ce_n    = ce_q;
    dout_n  = dout_q;
    dtack_n = dtack_q;
    wr_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          if (bus.cpu_rw) begin
            rom_a_n = bus.cpu_a[CODE_ROM_AW:1];
            ce_n    = ~(CODE_BANKS'(1) << bus.cpu_a[15:14]);
            state_n = ST_ADDR;
          end else begin
            // Writes into ROM space are acknowledged and dropped.
            wr_n    = ~(bus.cpu_uds_n & bus.cpu_lds_n);
            dtack_n = 1'b0;
            state_n = ST_ACK;
          end
        end
      end
      ST_ADDR: begin
        if (bus.cpu_as_n) begin
          ce_n    = '1;
          dtack_n = 1'b1;
          state_n = ST_IDLE;
        end else if (WAIT_STATES == 0) begin
          state_n = ST_LATCH;
        end else begin
          cnt_n   = WS_LOAD;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.cpu_as_n) begin
          ce_n    = '1;
          dtack_n = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt == 3'd0) begin
          state_n = ST_LATCH;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      ST_LATCH: begin
        if (bus.cpu_as_n) begin
          ce_n    = '1;
          dtack_n = 1'b1;
          state_n = ST_IDLE;
        end else begin
          dout_n  = {rom_hi_d, rom_lo_d};
          ce_n    = '1;
          dtack_n = 1'b0;
          state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        if (bus.cpu_as_n) begin
          dtack_n = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        ce_n    = '1;
        dtack_n = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.sel         = hit;
  assign bus.cpu_d_out   = dout_q;
  assign bus.cpu_dtack_n = dtack_q;
  assign bus.wr_ignored  = wr_q;
  assign rom_a           = rom_a_q;
  assign rom_ce_n        = ce_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_code_bus_ctl.sv
// Bench for code_bus_ctl: a zero-wait and a three-wait instance share one CPU
// bus; each has its own registered ROM model and expected-data queue.
module tb_code_bus_ctl;
  import foodfight_bus_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:1] cpu_a = '0;
  logic cpu_as_n = 1'b1, cpu_rw = 1'b1, cpu_uds_n = 1'b1, cpu_lds_n = 1'b1;

  code_bus_ctl_if b0 ();
  code_bus_ctl_if b3 ();
  assign b0.cpu_a = cpu_a;     assign b3.cpu_a = cpu_a;
  assign b0.cpu_as_n = cpu_as_n; assign b3.cpu_as_n = cpu_as_n;
  assign b0.cpu_rw = cpu_rw;   assign b3.cpu_rw = cpu_rw;
  assign b0.cpu_uds_n = cpu_uds_n; assign b3.cpu_uds_n = cpu_uds_n;
  assign b0.cpu_lds_n = cpu_lds_n; assign b3.cpu_lds_n = cpu_lds_n;

  logic [12:0] ra0, ra3;
  logic [3:0]  ce0, ce3;
  logic [7:0]  hi0 = '0, lo0 = '0, hi3 = '0, lo3 = '0;
  code_state_t st0, st3;

  code_bus_ctl #(.BASE(8'h00), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .rom_a(ra0), .rom_ce_n(ce0),
    .rom_hi_d(hi0), .rom_lo_d(lo0), .state_dbg(st0));
  code_bus_ctl #(.BASE(8'h00), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(b3), .rom_a(ra3), .rom_ce_n(ce3),
    .rom_hi_d(hi3), .rom_lo_d(lo3), .state_dbg(st3));

  function automatic logic [1:0] bank_of(input logic [3:0] ce);
    logic [1:0] b;
    b = 2'd0;
    for (int i = 0; i < 4; i++) if (!ce[i]) b = 2'(i);
    return b;
  endfunction

  function automatic logic [15:0] rom_word(input logic [1:0] b, input logic [12:0] a);
    if (b == 2'd0 && a == 13'h1000) return 16'h4E71;
    return {a[7:0] ^ {6'b0, b}, a[12:5] ^ 8'h3C};
  endfunction

  // ROM chips: one clock of registered latency while selected
  always_ff @(posedge clk) begin
    if (ce0 != 4'hF) {hi0, lo0} <= rom_word(bank_of(ce0), ra0);
    if (ce3 != 4'hF) {hi3, lo3} <= rom_word(bank_of(ce3), ra3);
  end

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q3[$];
  logic [15:0] last0 = 16'h0000;
  logic [15:0] exp_v;
  int n_checks = 0;
  int n_fail = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_read(input logic [23:1] a);
    cpu_a = a; cpu_rw = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
  endtask

  task automatic start_write(input logic [23:1] a, input logic uds, input logic lds);
    cpu_a = a; cpu_rw = 1'b0; cpu_uds_n = uds; cpu_lds_n = lds; cpu_as_n = 1'b0;
  endtask

  task automatic release_bus();
    cpu_as_n = 1'b1; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks += 6;
    if (ce0 !== 4'hF) begin n_fail++; $display("FAIL reset_ce got=%h exp=f", ce0); end
    if (ra0 !== 13'h0) begin n_fail++; $display("FAIL reset_rom_a got=%h exp=0", ra0); end
    if (b0.cpu_d_out !== 16'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", b0.cpu_d_out); end
    if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL reset_dtack got=%b exp=1", b0.cpu_dtack_n); end
    if (b0.wr_ignored !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", b0.wr_ignored); end
    if (st0 !== ST_IDLE || st3 !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d/%0d exp=0", st0, st3); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    start_read(23'h001000);
    exp_q0.push_back(rom_word(2'd0, 13'h1000));
    #1;
    n_checks++;
    if (b0.sel !== 1'b1) begin n_fail++; $display("FAIL basic_sel got=%b exp=1", b0.sel); end
    tick();
    n_checks += 2;
    if (ce0 !== 4'b1110) begin n_fail++; $display("FAIL basic_ce got=%b exp=1110", ce0); end
    if (ra0 !== 13'h1000) begin n_fail++; $display("FAIL basic_rom_a got=%h exp=1000", ra0); end
    tick();
    n_checks++;
    if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL basic_dtack_early got=%b exp=1", b0.cpu_dtack_n); end
    tick();
    n_checks += 2;
    if (b0.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL basic_dtack got=%b exp=0", b0.cpu_dtack_n); end
    exp_v = (exp_q0.size() > 0) ? exp_q0.pop_front() : 16'hxxxx;
    if (b0.cpu_d_out !== exp_v) begin n_fail++; $display("FAIL basic_data got=%h exp=%h", b0.cpu_d_out, exp_v); end
    last0 = exp_v;
    release_bus();
    tick();
    n_checks++;
    if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL basic_dtack_release got=%b exp=1", b0.cpu_dtack_n); end
    tick();
  endtask

  task automatic test_bank_bounds();
    logic [23:1] addr [3];
    logic [3:0]  ece  [3];
    logic [12:0] era  [3];
    addr[0] = 23'h001FFF; ece[0] = 4'b1110; era[0] = 13'h1FFF;
    addr[1] = 23'h002000; ece[1] = 4'b1101; era[1] = 13'h0000;
    addr[2] = 23'h007FFF; ece[2] = 4'b0111; era[2] = 13'h1FFF;
    for (int i = 0; i < 3; i++) begin
      start_read(addr[i]);
      exp_q0.push_back(rom_word(bank_of(ece[i]), era[i]));
      tick();
      n_checks += 2;
      if (ce0 !== ece[i]) begin n_fail++; $display("FAIL bank_ce[%0d] got=%b exp=%b", i, ce0, ece[i]); end
      if (ra0 !== era[i]) begin n_fail++; $display("FAIL bank_rom_a[%0d] got=%h exp=%h", i, ra0, era[i]); end
      cpu_a = 23'h000000;
      tick(); tick();
      n_checks += 3;
      exp_v = (exp_q0.size() > 0) ? exp_q0.pop_front() : 16'hxxxx;
      if (b0.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL bank_dtack[%0d] got=%b exp=0", i, b0.cpu_dtack_n); end
      if (b0.cpu_d_out !== exp_v) begin n_fail++; $display("FAIL bank_data[%0d] got=%h exp=%h", i, b0.cpu_d_out, exp_v); end
      if (ce0 !== 4'hF) begin n_fail++; $display("FAIL bank_ce_release[%0d] got=%b exp=1111", i, ce0); end
      last0 = exp_v;
      release_bus();
      tick(); tick();
    end
  endtask

  task automatic test_wait_states();
    int n;
    start_read(23'h000005);
    exp_q3.push_back(rom_word(2'd0, 13'h0005));
    n = 0;
    while (b3.cpu_dtack_n !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    n_checks += 2;
    if (n != 6) begin n_fail++; $display("FAIL wait_latency got=%0d exp=6", n); end
    exp_v = (exp_q3.size() > 0) ? exp_q3.pop_front() : 16'hxxxx;
    if (b3.cpu_d_out !== exp_v) begin n_fail++; $display("FAIL wait_data got=%h exp=%h", b3.cpu_d_out, exp_v); end
    last0 = exp_v;
    n_checks++;
    if (b0.cpu_d_out !== last0) begin n_fail++; $display("FAIL wait_w0_data got=%h exp=%h", b0.cpu_d_out, last0); end
    release_bus();
    tick(); tick();
  endtask

  task automatic test_write();
    start_write(23'h000080, 1'b0, 1'b0);
    tick();
    n_checks += 4;
    if (b0.wr_ignored !== 1'b1) begin n_fail++; $display("FAIL wr_pulse got=%b exp=1", b0.wr_ignored); end
    if (ce0 !== 4'hF) begin n_fail++; $display("FAIL wr_ce got=%b exp=1111", ce0); end
    if (b0.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL wr_dtack got=%b exp=0", b0.cpu_dtack_n); end
    if (st3 !== ST_ACK) begin n_fail++; $display("FAIL wr_state3 got=%0d exp=%0d", st3, ST_ACK); end
    tick();
    n_checks += 3;
    if (b0.wr_ignored !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_len got=%b exp=0", b0.wr_ignored); end
    if (ce0 !== 4'hF) begin n_fail++; $display("FAIL wr_ce_hold got=%b exp=1111", ce0); end
    if (b0.cpu_d_out !== last0) begin n_fail++; $display("FAIL wr_dout got=%h exp=%h", b0.cpu_d_out, last0); end
    release_bus();
    tick();
    n_checks++;
    if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL wr_dtack_release got=%b exp=1", b0.cpu_dtack_n); end
    start_write(23'h000080, 1'b1, 1'b1);
    tick();
    n_checks += 2;
    if (b0.wr_ignored !== 1'b0) begin n_fail++; $display("FAIL wr_nostrobe_pulse got=%b exp=0", b0.wr_ignored); end
    if (b0.cpu_dtack_n !== 1'b0) begin n_fail++; $display("FAIL wr_nostrobe_dtack got=%b exp=0", b0.cpu_dtack_n); end
    release_bus();
    tick(); tick();
  endtask

  task automatic test_out_of_region();
    start_read(23'h008000);
    #1;
    n_checks++;
    if (b0.sel !== 1'b0) begin n_fail++; $display("FAIL oor_sel got=%b exp=0", b0.sel); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks += 2;
      if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL oor_dtack[%0d] got=%b exp=1", i, b0.cpu_dtack_n); end
      if (st0 !== ST_IDLE || ce0 !== 4'hF) begin n_fail++; $display("FAIL oor_idle[%0d] got=%0d/%b exp=0/1111", i, st0, ce0); end
    end
    release_bus();
    tick();
  endtask

  task automatic test_abort_addr();
    start_read(23'h000123);
    tick();
    n_checks++;
    if (st0 !== ST_ADDR) begin n_fail++; $display("FAIL abort_in_addr got=%0d exp=%0d", st0, ST_ADDR); end
    release_bus();
    tick();
    n_checks += 4;
    if (ce0 !== 4'hF) begin n_fail++; $display("FAIL abort_ce got=%b exp=1111", ce0); end
    if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL abort_dtack got=%b exp=1", b0.cpu_dtack_n); end
    if (st0 !== ST_IDLE) begin n_fail++; $display("FAIL abort_state got=%0d exp=0", st0); end
    if (b0.cpu_d_out !== last0) begin n_fail++; $display("FAIL abort_dout got=%h exp=%h", b0.cpu_d_out, last0); end
    tick();
    n_checks++;
    if (b0.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL abort_dtack_later got=%b exp=1", b0.cpu_dtack_n); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    start_read(23'h000007);
    tick(); tick();
    n_checks++;
    if (st3 !== ST_WAIT) begin n_fail++; $display("FAIL rstw_in_wait got=%0d exp=%0d", st3, ST_WAIT); end
    reset_n = 1'b0;
    tick();
    n_checks += 5;
    if (ce3 !== 4'hF) begin n_fail++; $display("FAIL rstw_ce got=%b exp=1111", ce3); end
    if (ra3 !== 13'h0) begin n_fail++; $display("FAIL rstw_rom_a got=%h exp=0", ra3); end
    if (b3.cpu_d_out !== 16'h0) begin n_fail++; $display("FAIL rstw_dout got=%h exp=0", b3.cpu_d_out); end
    if (b3.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rstw_dtack got=%b exp=1", b3.cpu_dtack_n); end
    if (st3 !== ST_IDLE) begin n_fail++; $display("FAIL rstw_state got=%0d exp=0", st3); end
    reset_n = 1'b1;
    release_bus();
    tick();
    start_read(23'h000009);
    exp_q3.push_back(rom_word(2'd0, 13'h0009));
    n = 0;
    while (b3.cpu_dtack_n !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    n_checks += 2;
    if (n != 6) begin n_fail++; $display("FAIL rstw_latency got=%0d exp=6", n); end
    exp_v = (exp_q3.size() > 0) ? exp_q3.pop_front() : 16'hxxxx;
    if (b3.cpu_d_out !== exp_v) begin n_fail++; $display("FAIL rstw_data got=%h exp=%h", b3.cpu_d_out, exp_v); end
    release_bus();
    tick();
    n_checks++;
    if (b3.cpu_dtack_n !== 1'b1) begin n_fail++; $display("FAIL rstw_dtack_release got=%b exp=1", b3.cpu_dtack_n); end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_basic_read();
    test_bank_bounds();
    test_wait_states();
    test_write();
    test_out_of_region();
    test_abort_addr();
    test_reset_in_wait();
    n_checks++;
    if (exp_q0.size() != 0 || exp_q3.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_q0.size(), exp_q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
